// File: rtl/dbg_probe_capture.sv
// Debug probe selector with a registered live view and a DEPTH-deep capture window
// (triggered or immediate) that is drained word by word through a FIFO-style read port.
`timescale 1ns/1ps
module dbg_probe_capture #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  localparam int SEL_W = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       inClock,
  input  logic                       inReset,
  input  logic [NUM_CH*DATA_W-1:0]   inProbeData,
  input  logic [SEL_W-1:0]           inSel,
  input  logic                       inSelLoad,
  input  logic [1:0]                 inMode,
  input  logic [DATA_W-1:0]          inTrigMask,
  input  logic [DATA_W-1:0]          inTrigValue,
  input  logic                       inArm,
  input  logic                       inAbort,
  input  logic                       inReadEnable,
  output logic [DATA_W-1:0]          outLiveData,
  output logic [DATA_W-1:0]          outData,
  output logic                       outValid,
  output logic                       outTriggered,
  output logic                       outFull,
  output logic                       outEmpty,
  output logic [CNT_W-1:0]           outCount,
  output logic                       outBusy,
  output logic                       outReadError
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [PTR_W-1:0]   wrPtr_q;
  logic [PTR_W-1:0]   rdPtr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]  liveData_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               triggered_q;
  logic               readErr_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [DATA_W-1:0]  selData;
  logic [SEL_W-1:0]   selClamped;
  logic               trigMatch;
  logic               wrEn;

  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) selData = inProbeData[k*DATA_W +: DATA_W];
    end
  end

  assign selClamped = (32'(inSel) >= 32'(NUM_CH)) ? SEL_W'(NUM_CH - 1) : inSel;
  assign trigMatch  = ((selData ^ inTrigValue) & inTrigMask) == '0;
  // The matching sample itself becomes word 0, so ARMED writes in the same cycle it triggers.
  assign wrEn = !inReset && !inAbort &&
                ((state_q == ARMED && trigMatch) || state_q == CAPTURE);

  always_ff @(posedge inClock) begin
    if (wrEn) mem_q[wrPtr_q] <= selData;
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      liveData_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      triggered_q <= 1'b0;
      readErr_q   <= 1'b0;
    end else begin
      liveData_q <= selData;
      valid_q    <= 1'b0;
      if (inAbort) begin
        state_q <= IDLE;
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        count_q <= '0;
      end else begin
        if (wrEn) begin
          wrPtr_q <= wrPtr_q + PTR_W'(1);
          count_q <= count_q + CNT_W'(1);
        end
        case (state_q)
          IDLE: begin
            if (inSelLoad) sel_q <= selClamped;
            if (inArm && (inMode == 2'b01 || inMode == 2'b10)) begin
              state_q     <= (inMode == 2'b01) ? ARMED : CAPTURE;
              wrPtr_q     <= '0;
              rdPtr_q     <= '0;
              count_q     <= '0;
              triggered_q <= 1'b0;
              readErr_q   <= 1'b0;
            end
          end
          ARMED: begin
            if (trigMatch) begin
              triggered_q <= 1'b1;
              state_q     <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (count_q == CNT_W'(DEPTH - 1)) state_q <= DONE;
          end
          DONE: begin
            if (inSelLoad) sel_q <= selClamped;
            if (inReadEnable && count_q != '0) begin
              data_q  <= mem_q[rdPtr_q];
              valid_q <= 1'b1;
              rdPtr_q <= rdPtr_q + PTR_W'(1);
              count_q <= count_q - CNT_W'(1);
              if (count_q == CNT_W'(1)) state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
        // Placed after the arm branch so an underflow in the arming cycle still registers.
        if (inReadEnable && (state_q != DONE || count_q == '0)) readErr_q <= 1'b1;
      end
    end
  end

  assign outLiveData  = liveData_q;
  assign outData      = data_q;
  assign outValid     = valid_q;
  assign outTriggered = triggered_q;
  assign outFull      = (state_q == DONE);
  assign outEmpty     = (count_q == '0);
  assign outCount     = count_q;
  assign outBusy      = (state_q == ARMED) || (state_q == CAPTURE);
  assign outReadError = readErr_q;

endmodule

// File: tb/tb_dbg_probe_capture.sv
// Self-checking bench for dbg_probe_capture: table-driven select/live vectors, hand-written
// capture sequences, and a scoreboard queue that checks every popped word.
`timescale 1ns/1ps
module tb_dbg_probe_capture;

  localparam int NUM_CH = 6;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 5;

  logic                     inClock = 1'b0;
  logic                     inReset;
  logic [NUM_CH*DATA_W-1:0] inProbeData;
  logic [SEL_W-1:0]         inSel;
  logic                     inSelLoad;
  logic [1:0]               inMode;
  logic [DATA_W-1:0]        inTrigMask;
  logic [DATA_W-1:0]        inTrigValue;
  logic                     inArm;
  logic                     inAbort;
  logic                     inReadEnable;
  logic [DATA_W-1:0]        outLiveData;
  logic [DATA_W-1:0]        outData;
  logic                     outValid;
  logic                     outTriggered;
  logic                     outFull;
  logic                     outEmpty;
  logic [CNT_W-1:0]         outCount;
  logic                     outBusy;
  logic                     outReadError;

  int total = 0;
  int bad = 0;
  int validSeen = 0;
  logic [DATA_W-1:0] expQ[$];

  typedef struct {
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH*DATA_W-1:0] probe;
    logic [DATA_W-1:0]        expLive;
  } vec_t;
  vec_t vecs[7];

  // Six channels so a 3-bit select can exceed NUM_CH-1 and exercise clamping.
  dbg_probe_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .inClock(inClock), .inReset(inReset), .inProbeData(inProbeData), .inSel(inSel),
    .inSelLoad(inSelLoad), .inMode(inMode), .inTrigMask(inTrigMask), .inTrigValue(inTrigValue),
    .inArm(inArm), .inAbort(inAbort), .inReadEnable(inReadEnable), .outLiveData(outLiveData),
    .outData(outData), .outValid(outValid), .outTriggered(outTriggered), .outFull(outFull),
    .outEmpty(outEmpty), .outCount(outCount), .outBusy(outBusy), .outReadError(outReadError)
  );

  always #5 inClock = ~inClock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClock);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] v);
    inProbeData[ch*DATA_W +: DATA_W] = v;
  endtask

  always @(posedge inClock) begin
    #1;
    if (outValid) begin
      validSeen++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedPop: got %0h expected no pop", outData);
      end else begin
        checkOutput("popData", outData, expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 24'h65A321, 4'hA};
    vecs[1] = '{3'd0, 24'h65A321, 4'h1};
    vecs[2] = '{3'd5, 24'h65A321, 4'h6};
    vecs[3] = '{3'd7, 24'h65A321, 4'h6};
    vecs[4] = '{3'd6, 24'h9C7B84, 4'h9};
    vecs[5] = '{3'd1, 24'h9C7B84, 4'h8};
    vecs[6] = '{3'd4, 24'h9C7B84, 4'hC};

    inReset = 1'b1; inProbeData = 24'h65A321; inSel = '0; inSelLoad = 1'b0;
    inMode = 2'b00; inTrigMask = '0; inTrigValue = '0; inArm = 1'b0;
    inAbort = 1'b0; inReadEnable = 1'b0;
    tick(); tick();
    checkOutput("rstLive", outLiveData, 0);
    checkOutput("rstData", outData, 0);
    checkOutput("rstCount", outCount, 0);
    checkOutput("rstFlags", {outValid, outTriggered, outFull, outBusy, outReadError, outEmpty}, 6'b000001);
    inReset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      inProbeData = vecs[i].probe;
      inSel = vecs[i].sel;
      inSelLoad = 1'b1;
      tick();
      inSelLoad = 1'b0;
      tick();
      checkOutput($sformatf("live[%0d]", i), outLiveData, vecs[i].expLive);
    end
    checkOutput("liveFlags", {outTriggered, outFull, outBusy, outReadError, outEmpty}, 5'b00001);

    // Triggered capture on a counting probe, value 5 under full mask.
    inSel = 3'd0; inSelLoad = 1'b1; tick(); inSelLoad = 1'b0;
    applyStimulus(0, 4'h0);
    inMode = 2'b01; inTrigMask = 4'hF; inTrigValue = 4'h5; inArm = 1'b1;
    tick();
    inArm = 1'b0;
    checkOutput("armedBusy", outBusy, 1);
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(0, 4'(c));
      tick();
      if (c == 4) checkOutput("trigBefore", outTriggered, 0);
      if (c == 5) begin
        checkOutput("trigFired", outTriggered, 1);
        checkOutput("trigCount", outCount, 1);
      end
      if (c == 19) checkOutput("notFullYet", outFull, 0);
    end
    checkOutput("trigFull", outFull, 1);
    checkOutput("trigFullCount", outCount, 16);
    checkOutput("trigDoneBusy", outBusy, 0);
    validSeen = 0;
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(4'(5 + i));
      inReadEnable = 1'b1;
      tick();
      if (i == 7) checkOutput("midReadCount", outCount, 8);
    end
    inReadEnable = 1'b0;
    checkOutput("drainFull", outFull, 0);
    checkOutput("drainCount", outCount, 0);
    checkOutput("drainEmpty", outEmpty, 1);
    checkOutput("drainErr", outReadError, 0);
    tick();
    checkOutput("validOnce", outValid, 0);
    checkOutput("validCount1", validSeen, 16);

    // Immediate capture on a ramp: word 0 is the probe at the edge after arm.
    applyStimulus(0, 4'h9);
    inMode = 2'b10; inArm = 1'b1;
    tick();
    inArm = 1'b0;
    checkOutput("immTrigClr", outTriggered, 0);
    for (int j = 1; j <= 16; j++) begin
      applyStimulus(0, 4'(9 + j));
      tick();
      if (j == 15) checkOutput("immNotFull", {outFull, outBusy}, 2'b01);
    end
    checkOutput("immFull", outFull, 1);
    checkOutput("immCount", outCount, 16);
    for (int j = 1; j <= 16; j++) begin
      expQ.push_back(4'(9 + j));
      inReadEnable = 1'b1;
      tick();
    end
    inReadEnable = 1'b0;
    tick();
    checkOutput("validCount2", validSeen, 32);
    checkOutput("immIdle", {outBusy, outFull, outEmpty}, 3'b001);

    // Zero mask fires on the first ARMED cycle, then abort mid-capture.
    inMode = 2'b01; inTrigMask = 4'h0; inTrigValue = 4'h3; inArm = 1'b1;
    applyStimulus(0, 4'h7);
    tick();
    inArm = 1'b0;
    checkOutput("mask0Armed", {outBusy, outTriggered}, 2'b10);
    tick();
    checkOutput("mask0Fired", outTriggered, 1);
    checkOutput("mask0Count", outCount, 1);
    tick(); tick();
    checkOutput("midCapCount", outCount, 3);
    inAbort = 1'b1;
    tick();
    inAbort = 1'b0;
    checkOutput("abortState", {outBusy, outFull, outEmpty}, 3'b001);
    checkOutput("abortCount", outCount, 0);
    checkOutput("abortTrigHeld", outTriggered, 1);
    checkOutput("abortDataHeld", outData, 4'h9);

    // Select load ignored while ARMED; abort wins over a simultaneous match.
    applyStimulus(0, 4'h0);
    applyStimulus(2, 4'hE);
    inTrigMask = 4'hF; inTrigValue = 4'h5; inArm = 1'b1;
    tick();
    inArm = 1'b0;
    inSel = 3'd2; inSelLoad = 1'b1;
    tick();
    inSelLoad = 1'b0;
    tick();
    checkOutput("armedSelHeld", outLiveData, 4'h0);
    checkOutput("stillArmed", {outBusy, outTriggered}, 2'b10);
    applyStimulus(0, 4'h5);
    inAbort = 1'b1;
    tick();
    inAbort = 1'b0;
    checkOutput("abortWins", {outBusy, outTriggered, outFull}, 3'b000);
    checkOutput("abortWinsCount", outCount, 0);

    // Underflow read in IDLE sets the error; the next arm clears it.
    inReadEnable = 1'b1;
    tick();
    inReadEnable = 1'b0;
    checkOutput("readErrSet", {outReadError, outValid}, 2'b10);
    inMode = 2'b10; inArm = 1'b1;
    tick();
    inArm = 1'b0;
    checkOutput("readErrClr", {outReadError, outBusy}, 2'b01);
    inAbort = 1'b1;
    tick();
    inAbort = 1'b0;

    inMode = 2'b11; inArm = 1'b1;
    tick();
    checkOutput("mode11Ignored", outBusy, 0);
    inMode = 2'b00;
    tick();
    inArm = 1'b0;
    checkOutput("mode00Ignored", outBusy, 0);
    inSel = 3'd7; inSelLoad = 1'b1;
    tick();
    inSelLoad = 1'b0;
    tick();
    checkOutput("clampAfterArmed", outLiveData, inProbeData[5*DATA_W +: DATA_W]);
    checkOutput("queueDrained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_probe_capture.md
# dbg_probe_capture

Parametrised debug-observation block for the transceiver test top level. It selects one of NUM_CH internal probe buses (FIFO flags, coder and decoder I/Q, CORDIC and CDR outputs) onto a registered live output. It can also capture a DEPTH-deep window of the selected probe, either on a masked value trigger or immediately. The captured window is read out word by word through a FIFO-style port, which lets the bench observe internal behaviour through narrow test pins.

## Interface
- NUM_CH, default 8: number of probe channels; must be at least 2.
- DATA_W, default 4: width of each probe channel.
- DEPTH, default 16: capture buffer depth; power of 2, at least 2.
- SEL_W (derived): clog2(NUM_CH).
- CNT_W (derived): clog2(DEPTH+1).

Ports:
- inClock  in  1  the single clock.
- inReset  in  1  reset; synchronous and active-high.
- inProbeData  in  NUM_CH*DATA_W  probe buses; channel k occupies bits [k*DATA_W +: DATA_W].
- inSel  in  SEL_W  channel select.
- inSelLoad  in  1  loads inSel into the select register.
- inMode  in  2  00 = live only, 01 = triggered capture, 10 = immediate capture, 11 = reserved (treated as 00).
- inTrigMask  in  DATA_W  trigger compare mask.
- inTrigValue  in  DATA_W  trigger compare value.
- inArm  in  1  starts a capture.
- inAbort  in  1  returns the block to IDLE and discards the buffer.
- inReadEnable  in  1  pops one captured word.
- outLiveData  out  DATA_W  registered copy of the selected channel.
- outData  out  DATA_W  last popped word.
- outValid  out  1  outData was updated this cycle.
- outTriggered  out  1  trigger has fired; sticky.
- outFull  out  1  capture is complete (state DONE).
- outEmpty  out  1  buffer holds no unread words.
- outCount  out  CNT_W  number of unread words in the buffer.
- outBusy  out  1  state is ARMED or CAPTURE.
- outReadError  out  1  sticky read-underflow flag.

## Operation
- Select register selReg:
  - Loaded from inSel on inSelLoad, only in IDLE or DONE.
  - Ignored in ARMED and CAPTURE.
  - inSel values at or above NUM_CH clamp to NUM_CH-1.
- Live path: outLiveData <= channel[selReg] every cycle, in every state.
- Trigger match: (channel[selReg] & inTrigMask) == (inTrigValue & inTrigMask). A zero mask always matches.
- State IDLE:
  - inArm with mode 01 goes to ARMED.
  - inArm with mode 10 goes to CAPTURE.
  - inArm with mode 00 or 11 is ignored.
  - Arming clears the write and read pointers, outCount, outTriggered and outReadError.
- State ARMED:
  - When the trigger matches, the current sample is written as word 0, outTriggered is set, and the state goes to CAPTURE.
- State CAPTURE:
  - One sample is written per cycle.
  - In mode 10, the first write happens in the cycle after inArm is sampled.
  - After DEPTH words are written, the state goes to DONE.
- State DONE:
  - inReadEnable with outCount > 0 sets outData <= mem[rdPtr], pulses outValid, increments rdPtr and decrements outCount.
  - When outCount reaches 0, outFull deasserts and the state goes to IDLE.
- Reads outside DONE, or with outCount = 0, are ignored and set outReadError.
- inArm outside IDLE is ignored.
- inAbort in any state:
  - Next state IDLE; pointers and outCount cleared.
  - outTriggered, outData and outReadError are held.
  - inAbort wins over inArm, inReadEnable and trigger in the same cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset values:
  - State IDLE; selReg 0.
  - outLiveData, outData and outCount all 0.
  - outValid, outTriggered, outFull and outBusy all 0.
  - outReadError 0; outEmpty 1.
- inReset has priority over all other inputs.
- Select latency:
  - inSelLoad sampled at edge N gives selReg valid after N.
  - outLiveData then shows the new channel after edge N+1.
- Trigger latency: a probe value that matches at edge N is stored as word 0 at edge N. Words 1..DEPTH-1 are the probe values at edges N+1..N+DEPTH-1.
- outFull and DONE assert at the edge that writes the last word.
- outBusy is combinational from the state register.
- outCount and outEmpty are registered. During capture they track writes; during DONE they track reads.
- Read latency: inReadEnable at edge N gives outData and outValid after edge N. outValid is high for exactly one cycle per accepted pop.
- Back-to-back reads sustain one word per cycle.
- Exactly DEPTH reads empty the buffer. The state is IDLE in the cycle after the last pop.

## Test plan
- Reset, then apply inSel=3 with inSelLoad and channel 3 = 4'hA. Expect outLiveData = 4'hA two edges after the load; all flags at their reset values.
- Mode 01, mask 4'hF, value 4'h5, selected probe counting 0,1,2,... Expect outTriggered when the count reaches 5. Then 16 reads return 5..20 mod 16, outValid pulses 16 times, and the state returns to IDLE.
- Mode 10 with a constant-ramp probe and inArm at edge N. Expect the first word to equal the probe at edge N+1 and outFull after edge N+16.
- Mask 4'h0 in mode 01. Expect the trigger to fire on the first ARMED cycle.
- inAbort asserted mid-capture, simultaneously with a trigger match. Expect state IDLE, outCount 0 and outBusy 0. Then inReadEnable sets outReadError; a subsequent inArm clears it.
- Apply inSelLoad during ARMED. Expect selReg unchanged. Apply inSel = NUM_CH+1. Expect selReg to clamp to NUM_CH-1.
